// File: rtl/limn2600_pkg.sv
// Shared types for the Limn2600 memory arbiter.
//   arb_state_e  : arbiter FSM state (ARB_IDLE, ARB_BUSY)
//   arb_owner_e  : which requester owns the DRAM port (OWN_CPU, OWN_DMA)
//   ARB_ERR_DATA : all-ones read data returned on a watchdog abort
//                  (64 bits wide; users slice it down to their data width)
//   other_owner  : the requester that is not the given one
package limn2600_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } arb_owner_e;

  localparam logic [63:0] ARB_ERR_DATA = '1;

  function automatic arb_owner_e other_owner(input arb_owner_e o);
    return (o == OWN_CPU) ? OWN_DMA : OWN_CPU;
  endfunction

endpackage

// File: rtl/limn2600_rr_pick.sv
// Combinational two-way round-robin picker.
//   req0, req1  : requests from CPU / DMA
//   prio        : port that wins when both request (register owned by parent)
//   grant_valid : at least one request is present
//   grant_id    : winning port
module limn2600_rr_pick
  import limn2600_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
  input  arb_owner_e prio,
  output logic       grant_valid,
  output arb_owner_e grant_id
);

  always_comb begin
    grant_valid = req0 | req1;
    grant_id    = OWN_CPU;
    if (req0 && req1) grant_id = prio;
    else if (req1)    grant_id = OWN_DMA;
  end

endmodule

// File: rtl/limn2600_mem_arbiter.sv
// Round-robin arbiter sharing the single Limn2600 DRAM port between the CPU
// (port 0) and a DMA master (port 1). One request is captured at a time and
// held on the DRAM bus until mem_rdy; the owner then gets a one-cycle ack
// with the registered read data.
//
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   req*/we*/addr*/wdata*    : per-port request, captured at grant
//   ack*/rdata*              : per-port completion pulse and read data
//   err                      : watchdog abort flag, valid with ack
//   mem_valid/we/addr/wdata  : request held to the DRAM
//   mem_rdata, mem_rdy       : DRAM response
//
// Optional: define LIMN2600_ARB_TIMEOUT_EN to add a watchdog that aborts a
// transaction after TIMEOUT stalled BUSY cycles. Without it err is tied low
// and BUSY waits for mem_rdy indefinitely.
module limn2600_mem_arbiter
  import limn2600_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          err,
  output logic          mem_valid,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_rdy
);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("limn2600_mem_arbiter: TIMEOUT must be at least 1");
  end

  arb_state_e    state_q, state_d;
  arb_owner_e    prio_q, prio_d;
  arb_owner_e    owner_q, owner_d;
  logic          mem_valid_q, mem_valid_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          ack0_q, ack0_d, ack1_q, ack1_d;
  logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  logic          grant_valid;
  arb_owner_e    grant_id;

  // Completion of the current transaction, normal or aborted.
  logic          done;
  logic [DW-1:0] done_data;

`ifdef LIMN2600_ARB_TIMEOUT_EN
  localparam int CW_RAW = $clog2(TIMEOUT + 1);
  localparam int CW     = (CW_RAW < 8) ? 8 : ((CW_RAW > 16) ? 16 : CW_RAW);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`endif

  limn2600_rr_pick u_pick (
    .req0        (req0),
    .req1        (req1),
    .prio        (prio_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    owner_d     = owner_q;
    mem_valid_d = mem_valid_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    done        = 1'b0;
    done_data   = mem_rdata;
`ifdef LIMN2600_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = 1'b0;
`endif

    unique case (state_q)
      ARB_IDLE: begin
        if (grant_valid) begin
          state_d     = ARB_BUSY;
          owner_d     = grant_id;
          prio_d      = other_owner(grant_id);
          mem_valid_d = 1'b1;
          mem_we_d    = (grant_id == OWN_DMA) ? we1    : we0;
          mem_addr_d  = (grant_id == OWN_DMA) ? addr1  : addr0;
          mem_wdata_d = (grant_id == OWN_DMA) ? wdata1 : wdata0;
`ifdef LIMN2600_ARB_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end
      end
      ARB_BUSY: begin
        // mem_rdy takes precedence over a watchdog hit in the same cycle.
        if (mem_rdy) begin
          done = 1'b1;
        end
`ifdef LIMN2600_ARB_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT)) begin
          done      = 1'b1;
          done_data = ARB_ERR_DATA[DW-1:0];
          err_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = ARB_IDLE;
    endcase

    if (done) begin
      state_d     = ARB_IDLE;
      mem_valid_d = 1'b0;
      if (owner_q == OWN_CPU) begin
        ack0_d   = 1'b1;
        rdata0_d = done_data;
      end else begin
        ack1_d   = 1'b1;
        rdata1_d = done_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      prio_q      <= OWN_CPU;
      owner_q     <= OWN_CPU;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
`ifdef LIMN2600_ARB_TIMEOUT_EN
      cnt_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      owner_q     <= owner_d;
      mem_valid_q <= mem_valid_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
`ifdef LIMN2600_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      err_q       <= err_d;
`endif
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign mem_valid = mem_valid_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
`ifdef LIMN2600_ARB_TIMEOUT_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_limn2600_mem_arbiter.sv
// Bench for limn2600_mem_arbiter: directed stimulus pushes the expected
// completion (port, rdata, err) into a scoreboard queue; a negedge monitor
// pops and compares whenever an ack is seen. A small DRAM model raises
// mem_rdy on a programmable BUSY cycle.
module tb_limn2600_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1, err;
  logic [DW-1:0] rdata0, rdata1;
  logic          mem_valid, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_rdy;

  limn2600_mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .req1      (req1),
    .we0       (we0),
    .we1       (we1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .ack0      (ack0),
    .ack1      (ack1),
    .rdata0    (rdata0),
    .rdata1    (rdata1),
    .err       (err),
    .mem_valid (mem_valid),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_rdy   (mem_rdy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          port;
    logic [DW-1:0] data;
    logic          err;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic p, input logic [DW-1:0] d, input logic e);
    exp_t x;
    x.port = p; x.data = d; x.err = e;
    sb.push_back(x);
  endtask

  // DRAM model: rdy on BUSY cycle number dram_lat, or never when hung.
  int            dram_lat  = 1;
  bit            dram_hang = 1'b0;
  bit            dram_fix  = 1'b0;
  logic [DW-1:0] dram_val  = '0;
  int            busy_cnt  = 0;

  assign mem_rdata = dram_fix ? dram_val : (mem_addr ^ 32'h5A5A_0000);

  initial mem_rdy = 1'b0;
  always @(negedge clk) begin
    if (mem_valid === 1'b1) begin
      busy_cnt = busy_cnt + 1;
      mem_rdy  = !dram_hang && (busy_cnt == dram_lat);
    end else begin
      busy_cnt = 0;
      mem_rdy  = 1'b0;
    end
  end

  // Scoreboard monitor.
  exp_t mon_e;
  always @(negedge clk) begin
    if (ack0 === 1'b1 || ack1 === 1'b1) begin
      chk("ack_onehot", 32'(ack0 & ack1), 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_ack", 32'(ack1), 32'hFFFF_FFFF);
      end else begin
        mon_e = sb.pop_front();
        chk("ack_port", 32'(ack1), 32'(mon_e.port));
        chk("ack_rdata", ack1 ? rdata1 : rdata0, mon_e.data);
        chk("ack_err", 32'(err), 32'(mon_e.err));
      end
    end
  end

  // Wait for an ack, optionally checking the held bus every BUSY cycle.
  task automatic wait_ack(input string tag, input int maxc, input bit chk_bus,
                          input logic [AW-1:0] ea, input logic ewe,
                          input logic [DW-1:0] ewd, output int busy);
    int n;
    n = 0; busy = 0;
    do begin
      @(negedge clk);
      n++;
      if (mem_valid === 1'b1) begin
        busy++;
        if (chk_bus) begin
          chk({tag, "_mem_addr"}, mem_addr, ea);
          chk({tag, "_mem_we"}, 32'(mem_we), 32'(ewe));
          chk({tag, "_mem_wdata"}, mem_wdata, ewd);
        end
      end
    end while (!(ack0 === 1'b1 || ack1 === 1'b1) && n < maxc);
    if (!(ack0 === 1'b1 || ack1 === 1'b1)) chk({tag, "_ack_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_mem_valid"}, 32'(mem_valid), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_ack0"}, 32'(ack0), 32'd0);
    chk({tag, "_ack1"}, 32'(ack1), 32'd0);
    chk({tag, "_rdata0"}, rdata0, 32'd0);
    chk({tag, "_rdata1"}, rdata1, 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    int busy, cyc, prev, nack;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;

    // Single CPU read, DRAM answers on 3rd BUSY cycle.
    dram_fix = 1'b1; dram_val = 32'hDEAD_BEEF; dram_lat = 3;
    push(1'b0, 32'hDEAD_BEEF, 1'b0);
    req0 = 1'b1; addr0 = 32'h100;
    @(negedge clk);
    chk("rd_grant_latency", 32'(mem_valid), 32'd1);
    chk("rd_mem_addr0", mem_addr, 32'h100);
    wait_ack("rd", 20, 1'b1, 32'h100, 1'b0, 32'h0, busy);
    req0 = 1'b0;
    chk("rd_busy_cycles", 32'(busy), 32'd2);

    // DMA write, prio is 1 after the CPU grant and returns to 0.
    dram_val = 32'hCAFE_F00D; dram_lat = 1;
    push(1'b1, 32'hCAFE_F00D, 1'b0);
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h2000; wdata1 = 32'h1234_5678;
    wait_ack("wr", 20, 1'b1, 32'h2000, 1'b1, 32'h1234_5678, busy);
    req1 = 1'b0; we1 = 1'b0;
    chk("wr_busy_cycles", 32'(busy), 32'd1);

    // Contention: both held, rdy on 2nd BUSY cycle. CPU first (prio=0).
    dram_fix = 1'b0; dram_lat = 2;
    addr0 = 32'h40; addr1 = 32'h80;
    push(1'b0, 32'h5A5A_0040, 1'b0);
    push(1'b1, 32'h5A5A_0080, 1'b0);
    push(1'b0, 32'h5A5A_0040, 1'b0);
    push(1'b1, 32'h5A5A_0080, 1'b0);
    req0 = 1'b1; req1 = 1'b1;
    cyc = 0; prev = -1; nack = 0;
    while (nack < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (ack0 === 1'b1 || ack1 === 1'b1) begin
        if (prev >= 0) chk("cont_ack_spacing", 32'(cyc - prev), 32'd3);
        prev = cyc;
        nack++;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("cont_ack_count", 32'(nack), 32'd4);

    // Inputs change after grant; captured address must hold.
    dram_lat = 3;
    push(1'b0, 32'h5A5A_0010, 1'b0);
    req0 = 1'b1; addr0 = 32'h10;
    @(negedge clk);
    chk("chg_mem_addr_grant", mem_addr, 32'h10);
    addr0 = 32'h20;
    wait_ack("chg", 20, 1'b1, 32'h10, 1'b0, 32'h0, busy);
    req0 = 1'b0;
    chk("chg_rdata1_hold", rdata1, 32'h5A5A_0080);

    // Reset during the 2nd BUSY cycle abandons the transaction.
    dram_hang = 1'b1;
    req0 = 1'b1; addr0 = 32'h300;
    @(negedge clk);
    chk("rstb_busy1", 32'(mem_valid), 32'd1);
    @(negedge clk);
    rst = 1'b1; req0 = 1'b0;
    @(negedge clk);
    chk_reset_vals("rstb");
    rst = 1'b0; dram_hang = 1'b0; dram_lat = 1;

    // After reset prio must be back on the CPU.
    addr0 = 32'h40; addr1 = 32'h80;
    push(1'b0, 32'h5A5A_0040, 1'b0);
    push(1'b1, 32'h5A5A_0080, 1'b0);
    req0 = 1'b1; req1 = 1'b1;
    cyc = 0; nack = 0;
    while (nack < 2 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (ack0 === 1'b1 || ack1 === 1'b1) nack++;
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("post_rst_ack_count", 32'(nack), 32'd2);

    // DRAM never answers.
    dram_hang = 1'b1;
    req0 = 1'b1; addr0 = 32'h400;
`ifdef LIMN2600_ARB_TIMEOUT_EN
    push(1'b0, 32'hFFFF_FFFF, 1'b1);
    wait_ack("wdog", 30, 1'b0, '0, 1'b0, '0, busy);
    req0 = 1'b0;
    chk("wdog_busy_cycles", 32'(busy), 32'(TO + 1));
    @(negedge clk);
    chk("wdog_idle", 32'(mem_valid), 32'd0);
`else
    cyc = 0; busy = 0; nack = 0;
    repeat (30) begin
      @(negedge clk);
      if (mem_valid === 1'b1) busy++;
      if (ack0 === 1'b1 || ack1 === 1'b1) nack++;
    end
    chk("hang_busy_cycles", 32'(busy), 32'd30);
    chk("hang_no_ack", 32'(nack), 32'd0);
    req0 = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("hang_rst_valid", 32'(mem_valid), 32'd0);
`endif
    dram_hang = 1'b0;
    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
